instr_fetch: RTL and testbench

Instruction fetch sequencer for the 4-bit microcode processor. It holds the 16-entry by 8-bit program memory and the 4-bit program counter, and presents the current instruction on `instr_o`. It sits directly upstream of the jump/PC control stage: it drives `instr_o` into that stage and takes back its `pc_count` jump address to choose the next PC.

---
 rtl/instr_fetch.sv | 84 ++++++++
 tb/tb_instr_fetch.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: 16x8 program memory, 4-bit PC, FETCH/EXEC sequencing
// with halt-opcode, jump and end-of-memory handling.
module instr_fetch #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int IW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [IW-1:0] prog_data,
    input  logic [AW-1:0] pc_count,
    output logic [IW-1:0] instr_o,
    output logic [AW-1:0] pc,
    output logic          exec_en,
    output logic          busy,
    output logic          halted
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    state_t        state;
    logic [IW-1:0] mem [DEPTH];
    logic          prog_ok;

    assign prog_ok = (state == IDLE) || (state == HALT);

    // Program memory has no reset; its contents survive rst.
    always_ff @(posedge clk) begin
        if (prog_we && prog_ok) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pc      <= '0;
            instr_o <= '0;
            exec_en <= 1'b0;
            busy    <= 1'b0;
            halted  <= 1'b0;
        end else begin
            exec_en <= 1'b0;
            case (state)
                IDLE, HALT: begin
                    if (run) begin
                        pc     <= '0;
                        state  <= FETCH;
                        busy   <= 1'b1;
                        halted <= 1'b0;
                    end
                end
                FETCH: begin
                    instr_o <= mem[pc];
                    state   <= EXEC;
                    exec_en <= 1'b1;
                end
                EXEC: begin
                    // Halt opcode beats a jump; end of memory halts instead of wrapping.
                    if (instr_o == '1) begin
                        state  <= HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else if (pc_count != '0) begin
                        pc    <= pc_count;
                        state <= FETCH;
                    end else if (pc == AW'(DEPTH - 1)) begin
                        state  <= HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        pc    <= pc + 1'b1;
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a program-level model predicts the (pc, instr)
// sequence of every EXEC; a monitor pops and compares on each exec_en strobe.
module tb_instr_fetch;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int IW    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [IW-1:0] prog_data = '0;
    logic [AW-1:0] pc_count;
    logic [IW-1:0] instr_o;
    logic [AW-1:0] pc;
    logic          exec_en, busy, halted;

    instr_fetch #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
        .clk(clk), .rst(rst), .run(run), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .pc_count(pc_count), .instr_o(instr_o), .pc(pc),
        .exec_en(exec_en), .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] p;
        logic [IW-1:0] ins;
    } exp_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            last_exec = 0;
    int            exec_seen = 0;
    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [IW-1:0] ref_mem [DEPTH];
    bit            force_en = 1'b0;
    logic [AW-1:0] force_pc = '0;
    logic [AW-1:0] force_tgt = '0;

    // Downstream stage stand-in: opcode 8'hAx requests a jump to x; an override
    // can force a jump target while a chosen pc is executing.
    function automatic logic [AW-1:0] jump_of(input logic [AW-1:0] p, input logic [IW-1:0] ins,
                                              input bit fe, input logic [AW-1:0] fp,
                                              input logic [AW-1:0] ft);
        if (fe && p == fp) return ft;
        if (ins[7:4] == 4'hA) return ins[3:0];
        return '0;
    endfunction

    assign pc_count = jump_of(pc, instr_o, force_en, force_pc, force_tgt);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst && exec_en) begin
            exec_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_exec actual=pc%0h/%0h required=none", pc, instr_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("exec_pc", 32'(pc), 32'(mon_e.p));
                check("exec_instr", 32'(instr_o), 32'(mon_e.ins));
                check("exec_flags", 32'({busy, halted}), 32'h2);
                check("exec_gap", 32'(cyc - last_exec), 32'd2);
            end
            last_exec = cyc;
        end
    end

    task automatic wr(input logic [AW-1:0] a, input logic [IW-1:0] d);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(posedge clk);
        #1 prog_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"}, 32'(pc), 32'h0);
        check({tag, "_instr"}, 32'(instr_o), 32'h0);
        check({tag, "_flags"}, 32'({exec_en, busy, halted}), 32'h0);
    endtask

    // Run the program from pc 0. The model walks the program for up to 'limit'
    // instructions; if it has not halted by then, reset is asserted mid-EXEC.
    task automatic do_run(input int limit, input bit gate, input bit wr_en,
                          input logic [AW-1:0] wa, input logic [IW-1:0] wd);
        logic [AW-1:0] p;
        logic [AW-1:0] j;
        logic [IW-1:0] ins;
        bit            hm;
        int            n;
        int            i;
        p = '0; ins = '0; hm = 1'b0; n = 0;
        if (wr_en) ref_mem[wa] = wd;
        while (n < limit) begin
            ins = ref_mem[p];
            exp_q.push_back('{p: p, ins: ins});
            n++;
            if (ins == 8'hFF) begin hm = 1'b1; break; end
            j = jump_of(p, ins, force_en, force_pc, force_tgt);
            if (j != 0) p = j;
            else if (int'(p) == DEPTH - 1) begin hm = 1'b1; break; end
            else p = p + 1'b1;
        end
        exec_seen = 0;
        @(negedge clk);
        run = 1'b1; prog_we = wr_en; prog_addr = wa; prog_data = wd;
        @(posedge clk);
        #1;
        last_exec = cyc - 1;
        run = 1'b0;
        prog_we = gate; prog_addr = 4'h5; prog_data = 8'hAA;
        if (hm) begin
            for (i = 0; i < 2 * limit + 10 && !halted; i++) begin
                @(negedge clk); #2;
            end
            prog_we = 1'b0;
            check("halt_reached", 32'(halted), 32'h1);
            check("halt_pc", 32'(pc), 32'(p));
            check("halt_instr", 32'(instr_o), 32'(ins));
            check("halt_flags", 32'({exec_en, busy}), 32'h0);
            check("exec_count", 32'(exec_seen), 32'(n));
            check("queue_drained", 32'(exp_q.size()), 32'h0);
        end else begin
            for (i = 0; i < 2 * limit + 10 && exec_seen < n; i++) begin
                @(negedge clk); #2;
            end
            prog_we = 1'b0;
            check("exec_count", 32'(exec_seen), 32'(n));
            check("mid_exec", 32'(exec_en), 32'h1);
            rst = 1'b0;
            #1 check_reset_outputs("abort");
            exp_q.delete();
            @(negedge clk);
            rst = 1'b1;
            repeat (6) @(negedge clk);
            check("idle_after_abort", 32'({busy, halted}), 32'h0);
            check("no_exec_after_abort", 32'(exec_seen), 32'(n));
        end
    endtask

    initial begin
        logic [3:0] r;
        #2 rst = 1'b0;
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_exec", 32'({exec_en, busy, halted}), 32'h0);

        // Fill every word with non-halt, non-jump filler so the model never sees X.
        for (int a = 0; a < DEPTH; a++) wr(4'(a), {4'($urandom_range(0, 9)), 4'($urandom)});

        wr(4'h0, 8'h12); wr(4'h1, 8'h34); wr(4'h2, 8'h56); wr(4'h3, 8'hFF);
        do_run(100, 1'b0, 1'b0, '0, '0);

        wr(4'h2, 8'h25);
        force_en = 1'b1; force_pc = 4'h2; force_tgt = 4'h9;
        do_run(100, 1'b0, 1'b0, '0, '0);
        force_en = 1'b0;

        wr(4'h3, 8'h00); wr(4'h5, 8'h55);
        do_run(100, 1'b1, 1'b0, '0, '0);
        wr(4'h5, 8'hAA);
        do_run(100, 1'b0, 1'b0, '0, '0);

        do_run(3, 1'b0, 1'b0, '0, '0);
        do_run(100, 1'b0, 1'b1, 4'h0, 8'h77);

        for (int t = 0; t < 10; t++) begin
            for (int a = 0; a < DEPTH; a++) begin
                r = 4'($urandom_range(0, 9));
                if (r == 0) wr(4'(a), 8'hFF);
                else if (r < 4) wr(4'(a), {4'hA, 4'($urandom)});
                else wr(4'(a), {4'($urandom_range(0, 9)), 4'($urandom)});
            end
            do_run(40, 1'b0, 1'b0, '0, '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
